// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: state codes from the state machine,
// field widths and a packed-BCD increment helper.
package stopwatch_pkg;

  localparam int ESTADO_W = 3;
  localparam int BCD_W    = 4;
  localparam int TEMPO_W  = 24;
  localparam int DIGITS   = TEMPO_W / BCD_W;

  typedef enum logic [ESTADO_W-1:0] {
    INICIO = 3'd0,
    CONTAR = 3'd1,
    PAUSAR = 3'd2,
    PARAR  = 3'd3
  } estado_t;

  // Upper limit of digit i in {min_d,min_u,seg_d,seg_u,cent_d,cent_u}.
  // Index 0 is cent_u. The tens of seconds and tens of minutes stop at 5.
  function automatic logic [BCD_W-1:0] digit_max(input int i);
    return ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
  endfunction

  // Adds one centisecond to a packed MM:SS.CC value, wrapping 59:59.99 to 0.
  function automatic logic [TEMPO_W-1:0] tempo_inc(input logic [TEMPO_W-1:0] t);
    logic [TEMPO_W-1:0] r;
    logic               c;
    logic [BCD_W-1:0]   d;
    r = t;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = t[i*BCD_W +: BCD_W];
      if (c) begin
        if (d == digit_max(i)) begin
          r[i*BCD_W +: BCD_W] = '0;
        end else begin
          r[i*BCD_W +: BCD_W] = d + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/digito_bcd.sv
// One BCD digit of the time counter. Counts 0..MAX when enabled and
// raises carry on the enabled cycle that wraps it back to zero.
module digito_bcd
  import stopwatch_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = 4'd9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  assign carry = en && (q == MAX);

  // Digit register: reset and clear dominate, otherwise step and wrap at MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q == MAX) ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/contador_tempo.sv
// Stopwatch time base: divides clk down to a centisecond tick, counts
// MM:SS.CC in packed BCD and drives the display with the live time or
// a frozen split, following the state code from the state machine.
module contador_tempo
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ESTADO_W-1:0] estado,
  output logic                tick,
  output logic [TEMPO_W-1:0]  tempo,
  output logic [TEMPO_W-1:0]  display,
  output logic                estouro,
  output logic                congelado
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  logic [PRE_W-1:0]    prescaler;
  logic [ESTADO_W-1:0] estado_p1;
  logic [DIGITS-1:0]   carry;
  logic [TEMPO_W-1:0]  tempo_next;
  logic                contando;
  logic                limpa;
  logic                avanca;
  logic                entra_parar;

  // Split mode keeps the clock running; pausar and the invalid codes hold.
  assign contando    = (estado == CONTAR) || (estado == PARAR);
  assign limpa       = (estado == INICIO);
  assign avanca      = contando && (prescaler == PRE_MAX);
  assign entra_parar = (estado == PARAR) && (estado_p1 != PARAR);
  assign tempo_next  = avanca ? tempo_inc(tempo) : tempo;

  // Prescaler: free-runs while counting, keeps its phase while paused.
  always_ff @(posedge clk) begin
    if (reset || limpa) begin
      prescaler <= '0;
    end else if (contando) begin
      prescaler <= (prescaler == PRE_MAX) ? '0 : prescaler + 1'b1;
    end
  end

  // Tick is registered so it appears together with the advanced tempo.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick <= 1'b0;
    end else begin
      tick <= avanca;
    end
  end

  // Previous state code, used to find the first cycle of a split.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_p1 <= INICIO;
    end else begin
      estado_p1 <= estado;
    end
  end

  digito_bcd #(.MAX(4'd9)) u_cent_u (
    .clk(clk), .reset(reset), .clr(limpa), .en(avanca),
    .q(tempo[3:0]), .carry(carry[0])
  );

  digito_bcd #(.MAX(4'd9)) u_cent_d (
    .clk(clk), .reset(reset), .clr(limpa), .en(carry[0]),
    .q(tempo[7:4]), .carry(carry[1])
  );

  digito_bcd #(.MAX(4'd9)) u_seg_u (
    .clk(clk), .reset(reset), .clr(limpa), .en(carry[1]),
    .q(tempo[11:8]), .carry(carry[2])
  );

  digito_bcd #(.MAX(4'd5)) u_seg_d (
    .clk(clk), .reset(reset), .clr(limpa), .en(carry[2]),
    .q(tempo[15:12]), .carry(carry[3])
  );

  digito_bcd #(.MAX(4'd9)) u_min_u (
    .clk(clk), .reset(reset), .clr(limpa), .en(carry[3]),
    .q(tempo[19:16]), .carry(carry[4])
  );

  digito_bcd #(.MAX(4'd5)) u_min_d (
    .clk(clk), .reset(reset), .clr(limpa), .en(carry[4]),
    .q(tempo[23:20]), .carry(carry[5])
  );

  // Overflow flag: set when the top digit wraps, held until inicio.
  always_ff @(posedge clk) begin
    if (reset || limpa) begin
      estouro <= 1'b0;
    end else if (carry[5]) begin
      estouro <= 1'b1;
    end
  end

  // Display: follows tempo in contar, captures the pre-tick value on split entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      display   <= '0;
      congelado <= 1'b0;
    end else begin
      case (estado)
        INICIO: begin
          display   <= '0;
          congelado <= 1'b0;
        end
        CONTAR: begin
          display   <= tempo_next;
          congelado <= 1'b0;
        end
        PARAR: begin
          if (entra_parar) begin
            display   <= tempo;
            congelado <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_contador_tempo.sv
// Bench for contador_tempo with a 10-cycle tick (CLK_HZ=1000, TICK_HZ=100).
// The reference model keeps the time as a plain centisecond count.
module tb_contador_tempo;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int WRAP_CS = 360000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  estado = 3'd0;
  logic        tick;
  logic [23:0] tempo;
  logic [23:0] display;
  logic        estouro;
  logic        congelado;

  int checks = 0;
  int errors = 0;

  int m_ph   = 0;
  int m_cs   = 0;
  int m_disp = 0;
  int m_prev = 0;
  bit m_est  = 1'b0;
  bit m_cong = 1'b0;
  bit m_tick = 1'b0;

  contador_tempo #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk(clk), .reset(reset), .estado(estado), .tick(tick),
    .tempo(tempo), .display(display), .estouro(estouro), .congelado(congelado)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int cs);
    int m, s, c;
    m = cs / 6000;
    s = (cs / 100) % 60;
    c = cs % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic model_step();
    int old;
    if (reset) begin
      m_ph = 0; m_cs = 0; m_disp = 0; m_est = 0; m_cong = 0; m_tick = 0; m_prev = 0;
    end else begin
      m_tick = 0;
      if (estado == 3'd0) begin
        m_ph = 0; m_cs = 0; m_disp = 0; m_est = 0; m_cong = 0;
      end else if (estado == 3'd1 || estado == 3'd3) begin
        old = m_cs;
        if (m_ph == DIV - 1) begin
          m_ph = 0;
          m_tick = 1;
          m_cs = m_cs + 1;
          if (m_cs == WRAP_CS) begin
            m_cs = 0;
            m_est = 1;
          end
        end else begin
          m_ph = m_ph + 1;
        end
        if (estado == 3'd1) begin
          m_disp = m_cs;
          m_cong = 0;
        end else if (m_prev != 3) begin
          m_disp = old;
          m_cong = 1;
        end
      end
      m_prev = int'(estado);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    estado = 3'd1;
    repeat (3) cyc();
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
    checks++; if (tempo !== 24'h0) begin errors++; $display("FAIL reset_tempo: got %h want 000000", tempo); end
    checks++; if (display !== 24'h0) begin errors++; $display("FAIL reset_display: got %h want 000000", display); end
    checks++; if (estouro !== 1'b0) begin errors++; $display("FAIL reset_estouro: got %b want 0", estouro); end
    checks++; if (congelado !== 1'b0) begin errors++; $display("FAIL reset_congelado: got %b want 0", congelado); end
  endtask

  task automatic test_count();
    int nt = 0;
    int last = -1;
    int badgap = 0;
    reset = 1'b0;
    estado = 3'd1;
    for (int i = 1; i <= 100; i++) begin
      cyc();
      if (tick === 1'b1) begin
        if (last >= 0 && (i - last) != DIV) badgap++;
        last = i;
        nt++;
      end
    end
    checks++; if (nt != 10) begin errors++; $display("FAIL count_ticks: got %0d want 10", nt); end
    checks++; if (badgap != 0 || last != 100) begin errors++; $display("FAIL count_spacing: badgaps %0d last %0d want 0 and 100", badgap, last); end
    checks++; if (tempo !== 24'h000010) begin errors++; $display("FAIL count_tempo: got %h want 000010", tempo); end
    checks++; if (display !== 24'h000010) begin errors++; $display("FAIL count_display: got %h want 000010", display); end
    checks++; if (congelado !== 1'b0) begin errors++; $display("FAIL count_congelado: got %b want 0", congelado); end
  endtask

  task automatic test_pause();
    int n = 0;
    int extra;
    int nt = 0;
    estado = 3'd0;
    cyc();
    estado = 3'd1;
    while (tempo !== 24'h000005 && n < 200) begin cyc(); n++; end
    checks++; if (tempo !== 24'h000005) begin errors++; $display("FAIL pause_reach: got %h want 000005", tempo); end
    extra = $urandom_range(0, DIV - 2);
    repeat (extra) cyc();
    estado = 3'd2;
    repeat (50) begin cyc(); if (tick === 1'b1) nt++; end
    checks++; if (nt != 0) begin errors++; $display("FAIL pause_ticks: got %0d want 0", nt); end
    checks++; if (tempo !== 24'h000005) begin errors++; $display("FAIL pause_tempo: got %h want 000005", tempo); end
    estado = 3'd1;
    n = 0;
    do begin cyc(); n++; end while (tick !== 1'b1 && n < 3 * DIV);
    checks++; if (n != DIV - extra) begin errors++; $display("FAIL pause_resume_latency: got %0d want %0d", n, DIV - extra); end
  endtask

  task automatic test_split();
    int n = 0;
    estado = 3'd0;
    cyc();
    estado = 3'd1;
    while (tempo !== 24'h000123 && n < 1400) begin cyc(); n++; end
    checks++; if (tempo !== 24'h000123) begin errors++; $display("FAIL split_reach: got %h want 000123", tempo); end
    estado = 3'd3;
    repeat (30) cyc();
    checks++; if (display !== 24'h000123) begin errors++; $display("FAIL split_display: got %h want 000123", display); end
    checks++; if (congelado !== 1'b1) begin errors++; $display("FAIL split_congelado: got %b want 1", congelado); end
    checks++; if (tempo !== 24'h000126) begin errors++; $display("FAIL split_tempo: got %h want 000126", tempo); end
    estado = 3'd1;
    cyc();
    checks++; if (display !== tempo || tempo !== to_bcd(m_cs)) begin errors++; $display("FAIL split_resume: display %h tempo %h want both %h", display, tempo, to_bcd(m_cs)); end
    checks++; if (congelado !== 1'b0) begin errors++; $display("FAIL split_resume_congelado: got %b want 0", congelado); end
  endtask

  task automatic test_split_tick();
    int n = 0;
    logic [23:0] pre;
    estado = 3'd1;
    while (m_ph != DIV - 1 && n < 2 * DIV) begin cyc(); n++; end
    pre = to_bcd(m_cs);
    estado = 3'd3;
    cyc();
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL splittick_tick: got %b want 1", tick); end
    checks++; if (display !== pre) begin errors++; $display("FAIL splittick_display: got %h want %h", display, pre); end
    checks++; if (tempo !== to_bcd(m_cs)) begin errors++; $display("FAIL splittick_tempo: got %h want %h", tempo, to_bcd(m_cs)); end
  endtask

  task automatic test_wrap();
    int n = 0;
    estado = 3'd2;
    cyc();
    force dut.u_min_d.q  = 4'd5;
    force dut.u_min_u.q  = 4'd9;
    force dut.u_seg_d.q  = 4'd5;
    force dut.u_seg_u.q  = 4'd9;
    force dut.u_cent_d.q = 4'd9;
    force dut.u_cent_u.q = 4'd8;
    #1;
    release dut.u_min_d.q;
    release dut.u_min_u.q;
    release dut.u_seg_d.q;
    release dut.u_seg_u.q;
    release dut.u_cent_d.q;
    release dut.u_cent_u.q;
    m_cs = WRAP_CS - 2;
    cyc();
    checks++; if (tempo !== 24'h595998) begin errors++; $display("FAIL wrap_preload: got %h want 595998", tempo); end
    estado = 3'd1;
    while (estouro !== 1'b1 && n < 4 * DIV) begin cyc(); n++; end
    checks++; if (tempo !== 24'h000000 || tick !== 1'b1) begin errors++; $display("FAIL wrap_tempo: got %h tick %b want 000000 tick 1", tempo, tick); end
    checks++; if (estouro !== 1'b1) begin errors++; $display("FAIL wrap_estouro: got %b want 1", estouro); end
    repeat (25) cyc();
    checks++; if (estouro !== 1'b1) begin errors++; $display("FAIL wrap_sticky: got %b want 1", estouro); end
    estado = 3'd0;
    cyc();
    checks++; if (estouro !== 1'b0 || tempo !== 24'h0) begin errors++; $display("FAIL wrap_clear: estouro %b tempo %h want 0 000000", estouro, tempo); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    estado = 3'd0;
    cyc();
    estado = 3'd1;
    repeat (23) cyc();
    while (m_ph != 7 && n < 2 * DIV) begin cyc(); n++; end
    reset = 1'b1;
    cyc();
    checks++; if ({tick, estouro, congelado} !== 3'b000 || tempo !== 24'h0 || display !== 24'h0) begin
      errors++; $display("FAIL midreset_outputs: tick %b tempo %h display %h estouro %b congelado %b want all 0", tick, tempo, display, estouro, congelado);
    end
    reset = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (tick !== 1'b1 && n < 3 * DIV);
    checks++; if (n != DIV) begin errors++; $display("FAIL midreset_first_tick: got %0d want %0d", n, DIV); end
  endtask

  task automatic test_invalid();
    int nt = 0;
    logic [23:0] held;
    estado = 3'd1;
    repeat (13) cyc();
    held = to_bcd(m_cs);
    estado = 3'd5;
    repeat (30) begin cyc(); if (tick === 1'b1) nt++; end
    checks++; if (nt != 0) begin errors++; $display("FAIL invalid_ticks: got %0d want 0", nt); end
    checks++; if (tempo !== held) begin errors++; $display("FAIL invalid_tempo: got %h want %h", tempo, held); end
  endtask

  task automatic test_random();
    int hold;
    int r;
    for (int blk = 0; blk < 400; blk++) begin
      r = $urandom_range(0, 99);
      if (r < 3) estado = 3'd0;
      else if (r < 55) estado = 3'd1;
      else if (r < 70) estado = 3'd2;
      else if (r < 88) estado = 3'd3;
      else estado = 3'($urandom_range(4, 7));
      reset = ($urandom_range(0, 99) == 0);
      hold = $urandom_range(1, 12);
      for (int k = 0; k < hold; k++) begin
        cyc();
        reset = 1'b0;
        checks++;
        if (tick !== m_tick || tempo !== to_bcd(m_cs) || display !== to_bcd(m_disp) ||
            estouro !== m_est || congelado !== m_cong) begin
          errors++;
          $display("FAIL random_cycle: estado %0d got tick %b tempo %h display %h estouro %b congelado %b want %b %h %h %b %b",
                   estado, tick, tempo, display, estouro, congelado,
                   m_tick, to_bcd(m_cs), to_bcd(m_disp), m_est, m_cong);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_pause();
    test_split();
    test_split_tick();
    test_wrap();
    test_reset_mid();
    test_invalid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_tempo.md
Name: contador_tempo

Overview:
- Stopwatch time-base and BCD time counter, sequenced by the 3-bit `estado` code from the stopwatch state machine.
- Divides the system clock down to a 10 ms tick.
- Counts MM:SS.CC in packed BCD.
- Drives the display bus with either the live time or a frozen split time, depending on the state.
- Sits between the state machine and the 7-segment decoder.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz (one centisecond); DIV = CLK_HZ/TICK_HZ, must be an integer >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- estado  in  3  state code: 0 inicio, 1 contar, 2 pausar, 3 parar
- tick  out  1  one-cycle pulse when the time counter advances
- tempo  out  24  live time, packed BCD {min_d,min_u,seg_d,seg_u,cent_d,cent_u}
- display  out  24  time shown to the user, same packing
- estouro  out  1  sticky flag, set on wrap from 59:59.99
- congelado  out  1  high while display holds a split value

Behaviour:
- Reset (reset=1 at posedge clk): prescaler=0, tempo=0, display=0, tick=0, estouro=0, congelado=0. Reset has priority over everything.
- Prescaler: counts 0..DIV-1 while estado is contar or parar. It holds its value in pausar and clears to 0 in inicio.
- tick=1 for exactly the cycle after the edge where the prescaler is at DIV-1 and advancing. tempo updates on that same edge, so tick and the new tempo are visible together.
- The prescaler keeps its phase across pausar; pausing never loses a partial tick.
- Counter chain, each digit advancing when its lower neighbour wraps:
  - cent_u 0..9, cent_d 0..9
  - seg_u 0..9, seg_d 0..5
  - min_u 0..9, min_d 0..5
- Wrap: 59:59.99 + tick -> 00:00.00 with estouro set to 1. estouro stays set until inicio or reset.
- Per-state behaviour:
  - inicio: tempo, display, prescaler, estouro and congelado all cleared on every cycle.
  - contar: counting enabled; display = tempo (same-cycle copy, registered); congelado=0.
  - pausar: counting halted; tempo and display frozen; congelado keeps its previous value.
  - parar (split): counting continues. On the first cycle in parar (previous estado != 3), display captures the current tempo and congelado becomes 1. Display then holds while tempo keeps running.
- State transitions:
  - parar -> contar: display resumes tracking tempo from the first contar cycle; congelado=0.
  - pausar -> parar: a new split is captured (entry edge).
  - parar -> pausar -> parar: each entry into parar recaptures.
- Invalid codes 4-7: treated as pausar (hold all state, no tick).
- Simultaneous events:
  - estado changes from contar to pausar on the same edge the prescaler would wrap: no tick; the prescaler stays at DIV-1.
  - Entry into parar coincides with a tick: display captures the pre-increment tempo.
- A previous-state register is needed to detect entry into parar; it resets to inicio (0).

Decomposition:
- Shared package (stopwatch_pkg) holds:
  - state encoding constants INICIO=0, CONTAR=1, PAUSAR=2, PARAR=3, shared with the state machine
  - ESTADO_W=3
  - BCD_W=4
  - TEMPO_W=24
- One sub-module, digito_bcd:
  - parameter MAX (9 or 5)
  - inputs: clk, reset, clr, en
  - outputs: q[3:0], and carry, which is high when en and q==MAX
  - instantiated six times, en chained through the carries

Test Plan (CLK_HZ=1000, TICK_HZ=100, so DIV=10):
- Reset, then estado=1 for 100 cycles: exactly 10 ticks, 10 cycles apart; tempo=display=24'h000010 (0.10 s); congelado=0.
- Count to tempo=24'h000005, then estado=2 for 50 cycles, then estado=1: no ticks while paused. The first tick after resume arrives (10 - prescaler phase at pause) cycles after returning to contar.
- At tempo=24'h000123, estado=3 for 30 cycles: display stays 24'h000123, congelado=1, tempo reaches 24'h000126. Return to estado=1: display=tempo next cycle.
- Force tempo near 24'h595999 (or run to it), one more tick: tempo=24'h000000, estouro=1 and sticky. estado=0 clears estouro and tempo.
- reset=1 mid-count in contar with prescaler at 7: all outputs 0 on the next edge. After reset drops, the first tick comes a full 10 cycles later.
- estado=5 while counting: behaves as pausar, with no tick and tempo held. Also check: entry into parar on the same edge as a tick captures the pre-increment value.
